sm_data_in_poller: RTL and testbench



---
 rtl/sm_data_in_poller.sv | 176 +++++++++++++++++
 tb/tb_sm_data_in_poller.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_data_in_poller.sv
// Periodic poller for the SM data-in PIO: samples the PIO every PERIOD clocks and
// queues changed values with a poll-count timestamp for the CPU to read.
module sm_data_in_poller #(
    parameter int DATA_W     = 32,
    parameter int PERIOD     = 1000,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    output logic [1:0]        pio_address,
    input  logic [DATA_W-1:0] pio_readdata,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq
);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int WAIT_W = $clog2(PERIOD);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PERIOD - 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_WAIT
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                enable;
    logic                irq_en;
    logic                overflow;
    logic                baseline_valid;
    logic [DATA_W-1:0]   last_value;
    logic [TS_W-1:0]     ts_cnt;
    logic [DATA_W-1:0]   mem_data [FIFO_DEPTH];
    logic [TS_W-1:0]     mem_ts   [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_W-1:0]    count;
    logic                empty;
    logic                full;
    logic                capture;
    logic                push_req;
    logic                push;
    logic                pop;
    logic                ovf_set;
    logic [31:0]         rd_mux;
    logic                unused_wdata;

    assign unused_wdata = ^avs_writedata[31:3];

    always_comb begin
        state_next  = state;
        pio_address = 2'd1;
        case (state)
            S_IDLE:    if (enable) state_next = S_ISSUE;
            S_ISSUE: begin
                pio_address = 2'd0;
                state_next  = S_CAPTURE;
            end
            S_CAPTURE: state_next = S_WAIT;
            S_WAIT:    if (wait_cnt == '0) state_next = S_ISSUE;
            default:   state_next = S_IDLE;
        endcase
        if (!enable) state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == S_CAPTURE)
                wait_cnt <= WAIT_LOAD;
            else if (state == S_WAIT && wait_cnt != '0)
                wait_cnt <= wait_cnt - WAIT_W'(1);
        end
    end

    // A capture with enable already cleared is dropped entirely, timestamp included.
    assign capture  = (state == S_CAPTURE) && enable;
    assign push_req = capture && (!baseline_valid || pio_readdata != last_value);
    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign pop      = avs_read && avs_address == 2'd2 && !empty;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            baseline_valid <= 1'b0;
            last_value     <= '0;
            ts_cnt         <= '0;
        end else if (state_next == S_IDLE) begin
            baseline_valid <= 1'b0;
        end else if (capture) begin
            last_value     <= pio_readdata;
            baseline_valid <= 1'b1;
            ts_cnt         <= ts_cnt + TS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= pio_readdata;
            mem_ts[wr_ptr]   <= ts_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push)
                count <= count - CNT_W'(1);
        end
    end

    // A new overflow event wins over a simultaneous software clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            enable   <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (avs_write && avs_address == 2'd1) begin
                enable <= avs_writedata[0];
                irq_en <= avs_writedata[1];
            end
            if (ovf_set)
                overflow <= 1'b1;
            else if (avs_write && avs_address == 2'd0 && avs_writedata[2])
                overflow <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            2'd0: begin
                rd_mux[0]    = empty;
                rd_mux[1]    = full;
                rd_mux[2]    = overflow;
                rd_mux[15:8] = 8'(count);
            end
            2'd1: rd_mux[1:0] = {irq_en, enable};
            2'd2: if (!empty) rd_mux[DATA_W-1:0] = mem_data[rd_ptr];
            default: if (!empty) rd_mux[TS_W-1:0] = mem_ts[rd_ptr];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            if (avs_read) avs_readdata <= rd_mux;
            irq <= irq_en && (!empty || overflow);
        end
    end

endmodule

// File: tb/tb_sm_data_in_poller.sv
// Self-checking bench for sm_data_in_poller: directed scenarios plus a randomized run
// checked against a queue-based model of the poller's externally visible behaviour.
module tb_sm_data_in_poller;
    localparam int DATA_W     = 32;
    localparam int PERIOD     = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int TS_W       = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        pio_address;
    logic [DATA_W-1:0] pio_readdata = '0;
    logic [1:0]        avs_address = 2'd0;
    logic              avs_read = 1'b0;
    logic              avs_write = 1'b0;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic              irq;

    logic [DATA_W-1:0] pio_value = '0;
    int                n_cmp = 0;
    int                n_bad = 0;
    int                cyc = 0;
    int                t_en;
    logic [31:0]       ov_first;
    logic [31:0]       ov_val;

    sm_data_in_poller #(
        .DATA_W(DATA_W), .PERIOD(PERIOD), .FIFO_DEPTH(FIFO_DEPTH), .TS_W(TS_W)
    ) dut (
        .clk(clk), .reset(reset), .pio_address(pio_address), .pio_readdata(pio_readdata),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // The PIO registers its data; any address other than 0 reads back as 0.
    always @(posedge clk) pio_readdata <= (pio_address == 2'd0) ? pio_value : '0;

    // Reference model: polls occur at fixed offsets from the enabling write, the
    // change FIFO is a queue, and every registered output uses pre-edge state.
    typedef struct {
        logic [DATA_W-1:0] data;
        logic [TS_W-1:0]   ts;
    } entry_t;

    entry_t            m_q[$];
    bit                m_en, m_irq_en, m_ovf, m_base;
    int                m_e;
    logic [DATA_W-1:0] m_last, pio_prev;
    logic [TS_W-1:0]   m_ts;
    logic [31:0]       m_rd = '0;
    logic              m_irq = 1'b0;
    logic [1:0]        m_pio_addr = 2'd1;

    always @(posedge clk) begin
        bit     ovf_set;
        entry_t ent;
        cyc++;
        ovf_set = 1'b0;
        if (reset) begin
            m_q.delete();
            m_en = 0; m_irq_en = 0; m_ovf = 0; m_base = 0; m_e = 0;
            m_last = '0; m_ts = '0; m_rd = '0; m_irq = 1'b0; m_pio_addr = 2'd1;
        end else begin
            m_irq = m_irq_en && (m_q.size() != 0 || m_ovf);
            m_pio_addr = (m_en && cyc >= m_e + 1 && (cyc - m_e - 1) % PERIOD == 0) ? 2'd0 : 2'd1;
            if (avs_read) begin
                m_rd = '0;
                case (avs_address)
                    2'd0: m_rd = {16'd0, 8'(m_q.size()), 5'd0, m_ovf,
                                  m_q.size() == FIFO_DEPTH, m_q.size() == 0};
                    2'd1: m_rd = {30'd0, m_irq_en, m_en};
                    2'd2: if (m_q.size() != 0) begin
                        ent  = m_q.pop_front();
                        m_rd = 32'(ent.data);
                    end
                    default: if (m_q.size() != 0) m_rd = 32'(m_q[0].ts);
                endcase
            end
            if (m_en && cyc - 1 >= m_e + 2 && (cyc - 1 - m_e - 2) % PERIOD == 0) begin
                if (!m_base || pio_prev != m_last) begin
                    if (m_q.size() < FIFO_DEPTH) begin
                        ent.data = pio_prev;
                        ent.ts   = m_ts;
                        m_q.push_back(ent);
                    end else begin
                        m_ovf   = 1;
                        ovf_set = 1'b1;
                    end
                end
                m_last = pio_prev;
                m_base = 1;
                m_ts++;
            end
            if (avs_write) begin
                if (avs_address == 2'd1) begin
                    if (avs_writedata[0] && !m_en) m_e = cyc;
                    if (!avs_writedata[0]) m_base = 0;
                    m_en     = avs_writedata[0];
                    m_irq_en = avs_writedata[1];
                end else if (avs_address == 2'd0 && avs_writedata[2] && !ovf_set) begin
                    m_ovf = 0;
                end
            end
        end
        pio_prev = pio_value;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_cycle(input int t);
        while (cyc < t) tick();
    endtask

    task automatic cpu_write(input logic [1:0] a, input logic [31:0] d);
        avs_address   = a;
        avs_writedata = d;
        avs_write     = 1'b1;
        tick();
        avs_write = 1'b0;
    endtask

    task automatic cpu_read(input logic [1:0] a);
        avs_address = a;
        avs_read    = 1'b1;
        tick();
        avs_read = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        avs_read = 1'b0;
        avs_write = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (pio_address !== 2'd1) begin
            n_bad++; $display("[TB] FAIL reset_pio_address: got %0d expected 1", pio_address);
        end
        n_cmp++;
        if (avs_readdata !== 32'd0 || irq !== 1'b0) begin
            n_bad++; $display("[TB] FAIL reset_outputs: got rd=%h irq=%b expected 0/0", avs_readdata, irq);
        end
        cpu_read(2'd0);
        n_cmp++;
        if (avs_readdata !== 32'h1) begin
            n_bad++; $display("[TB] FAIL reset_status: got %h expected 00000001", avs_readdata);
        end
        cpu_read(2'd1);
        n_cmp++;
        if (avs_readdata !== 32'h0) begin
            n_bad++; $display("[TB] FAIL reset_control: got %h expected 00000000", avs_readdata);
        end
    endtask

    task automatic test_poll_timing();
        int          e;
        logic [1:0]  exp_addr;
        logic [1:0]  adr [4] = '{2'd0, 2'd3, 2'd2, 2'd0};
        logic [31:0] exp  [4] = '{32'h100, 32'h0, 32'hA5, 32'h1};
        do_reset();
        pio_value = 32'hA5;
        cpu_write(2'd1, 32'h1);
        e = cyc;
        for (int i = 0; i < 3 * PERIOD + 2; i++) begin
            tick();
            exp_addr = ((cyc - e - 1) % PERIOD == 0) ? 2'd0 : 2'd1;
            n_cmp++;
            if (pio_address !== exp_addr) begin
                n_bad++; $display("[TB] FAIL issue_timing@E+%0d: got %0d expected %0d", cyc - e, pio_address, exp_addr);
            end
        end
        for (int i = 0; i < 4; i++) begin
            cpu_read(adr[i]);
            n_cmp++;
            if (avs_readdata !== exp[i]) begin
                n_bad++; $display("[TB] FAIL single_entry[%0d]: got %h expected %h", i, avs_readdata, exp[i]);
            end
        end
    endtask

    task automatic test_change();
        int          e;
        logic [1:0]  adr [6] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] exp  [6] = '{32'h200, 32'h0, 32'hA5, 32'h2, 32'h5A, 32'h1};
        do_reset();
        pio_value = 32'hA5;
        cpu_write(2'd1, 32'h1);
        e = cyc;
        goto_cycle(e + 2 * PERIOD);
        pio_value = 32'h5A;
        goto_cycle(e + 4 * PERIOD);
        for (int i = 0; i < 6; i++) begin
            cpu_read(adr[i]);
            n_cmp++;
            if (avs_readdata !== exp[i]) begin
                n_bad++; $display("[TB] FAIL change_entries[%0d]: got %h expected %h", i, avs_readdata, exp[i]);
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        ov_val    = $urandom;
        ov_first  = ov_val;
        pio_value = ov_val;
        cpu_write(2'd1, 32'h3);
        t_en = cyc;
        for (int k = 1; k < 10; k++) begin
            goto_cycle(t_en + k * PERIOD);
            ov_val    = ov_val ^ 32'(1 + $urandom_range(0, 254));
            pio_value = ov_val;
            if (k == 8) begin
                cpu_read(2'd0);
                n_cmp++;
                if (avs_readdata !== 32'h0802 || irq !== 1'b1) begin
                    n_bad++; $display("[TB] FAIL full_no_ovf: got %h irq=%b expected 00000802 irq=1", avs_readdata, irq);
                end
            end
        end
        goto_cycle(t_en + 10 * PERIOD);
        cpu_read(2'd0);
        n_cmp++;
        if (avs_readdata !== 32'h0806 || irq !== 1'b1) begin
            n_bad++; $display("[TB] FAIL overflow_set: got %h irq=%b expected 00000806 irq=1", avs_readdata, irq);
        end
        cpu_write(2'd0, 32'h4);
        cpu_read(2'd0);
        n_cmp++;
        if (avs_readdata !== 32'h0802) begin
            n_bad++; $display("[TB] FAIL overflow_clear: got %h expected 00000802", avs_readdata);
        end
    endtask

    task automatic test_pop_push_full();
        int k;
        k = (cyc - t_en) / PERIOD + 1;
        goto_cycle(t_en + k * PERIOD);
        ov_val    = ov_val ^ 32'h8000_0001;
        pio_value = ov_val;
        goto_cycle(t_en + k * PERIOD + 2);
        cpu_read(2'd2);
        n_cmp++;
        if (avs_readdata !== ov_first) begin
            n_bad++; $display("[TB] FAIL pop_push_oldest: got %h expected %h", avs_readdata, ov_first);
        end
        cpu_read(2'd0);
        n_cmp++;
        if (avs_readdata !== 32'h0802) begin
            n_bad++; $display("[TB] FAIL pop_push_count: got %h expected 00000802", avs_readdata);
        end
        n_cmp++;
        if (avs_readdata !== m_rd) begin
            n_bad++; $display("[TB] FAIL pop_push_model: got %h expected %h", avs_readdata, m_rd);
        end
    endtask

    task automatic test_disable_reenable();
        int          e;
        logic [1:0]  adr [6] = '{2'd0, 2'd3, 2'd2, 2'd3, 2'd2, 2'd0};
        logic [31:0] exp  [6] = '{32'h200, 32'h0, 32'h1234_5678, 32'h2, 32'h1234_5678, 32'h1};
        do_reset();
        pio_value = 32'h1234_5678;
        cpu_write(2'd1, 32'h1);
        e = cyc;
        goto_cycle(e + PERIOD + 5);
        cpu_write(2'd1, 32'h0);
        for (int i = 0; i < 2 * PERIOD; i++) begin
            tick();
            n_cmp++;
            if (pio_address !== 2'd1) begin
                n_bad++; $display("[TB] FAIL disabled_no_poll@%0d: got %0d expected 1", i, pio_address);
            end
        end
        cpu_write(2'd1, 32'h1);
        e = cyc;
        tick();
        n_cmp++;
        if (pio_address !== 2'd0) begin
            n_bad++; $display("[TB] FAIL reenable_issue: got %0d expected 0", pio_address);
        end
        goto_cycle(e + PERIOD);
        for (int i = 0; i < 6; i++) begin
            cpu_read(adr[i]);
            n_cmp++;
            if (avs_readdata !== exp[i]) begin
                n_bad++; $display("[TB] FAIL reenable_entries[%0d]: got %h expected %h", i, avs_readdata, exp[i]);
            end
        end
    endtask

    task automatic test_empty_read();
        do_reset();
        cpu_write(2'd1, 32'h2);
        cpu_read(2'd2);
        n_cmp++;
        if (avs_readdata !== 32'h0) begin
            n_bad++; $display("[TB] FAIL empty_data: got %h expected 00000000", avs_readdata);
        end
        cpu_read(2'd0);
        tick();
        n_cmp++;
        if (avs_readdata !== 32'h1 || irq !== 1'b0) begin
            n_bad++; $display("[TB] FAIL empty_status: got %h irq=%b expected 00000001 irq=0", avs_readdata, irq);
        end
    endtask

    task automatic test_random();
        int         op;
        logic [1:0] a;
        do_reset();
        pio_value = 32'($urandom_range(0, 3));
        cpu_write(2'd1, 32'h3);
        for (int i = 0; i < 600; i++) begin
            if (i == 300) begin
                do_reset();
                cpu_write(2'd1, 32'h3);
            end
            if ($urandom_range(0, 5) == 0) pio_value = 32'($urandom_range(0, 3));
            op = $urandom_range(0, 39);
            if (op < 10) begin
                a = 2'($urandom_range(0, 3));
                cpu_read(a);
                n_cmp++;
                if (avs_readdata !== m_rd) begin
                    n_bad++; $display("[TB] FAIL rand_read a=%0d @%0d: got %h expected %h", a, i, avs_readdata, m_rd);
                end
            end else if (op == 10) begin
                cpu_write(2'd0, 32'h4);
            end else if (op == 11) begin
                cpu_write(2'd1, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
            end else begin
                tick();
            end
            n_cmp++;
            if (irq !== m_irq || pio_address !== m_pio_addr) begin
                n_bad++; $display("[TB] FAIL rand_outputs @%0d: got irq=%b addr=%0d expected irq=%b addr=%0d",
                                  i, irq, pio_address, m_irq, m_pio_addr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_poll_timing();
        test_change();
        test_overflow();
        test_pop_push_full();
        test_disable_reenable();
        test_empty_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
